fir4_seq_ctrl: RTL and testbench

FIR4_SEQ_CTRL -- requirements
Module: fir4_seq_ctrl

---
 rtl/fir_pkg.sv | 17 +
 rtl/rca_add.sv | 22 ++
 rtl/fir4_seq_ctrl.sv | 114 +++++++++++
 tb/tb_fir4_seq_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the sequential 4-tap moving-sum block.
package fir_pkg;

   // Controller states: waiting for a sample, accumulating taps, holding a result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NTAPS = 4;
   localparam int TAP_W = 2;

   // Index of the final tap; the accumulate phase ends when the counter reaches it.
   localparam logic [TAP_W-1:0] TAP_LAST = 2'd3;

endpackage

// File: rtl/rca_add.sv
// Ripple-carry adder with carry-in tied low; the single shared adder of the block.
module rca_add #(
   parameter int W = 18
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o
);

   // Bit-serial carry chain; carry out of the top bit is dropped because the
   // caller sizes W so the sum can never exceed it.
   always_comb begin
      logic carry;
      carry = 1'b0;
      sum_o = '0;
      for (int i = 0; i < W; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
         carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
   end

endmodule

// File: rtl/fir4_seq_ctrl.sv
// Sequential 4-tap moving sum: one accepted sample starts four add cycles on a
// shared adder, then the result is held until the consumer takes it.
module fir4_seq_ctrl
   import fir_pkg::*;
#(
   parameter int w = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [w-1:0] a,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [w+1:0] s,
   output logic         busy
);

   state_t             state_q;
   logic [w-1:0]       h_q [NTAPS];
   logic [TAP_W-1:0]   tap_q;
   logic [w+1:0]       acc_q;
   logic [w+1:0]       s_q;
   logic               out_valid_q;
   logic               busy_q;
   logic               in_ready_q;
   logic [w+1:0]       tap_val_d;
   logic [w+1:0]       sum_d;
   logic               accept_d;

   assign accept_d  = in_valid & in_ready_q;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign busy      = busy_q;

   // Select the history entry addressed by the tap counter, zero-extended to sum width.
   always_comb begin
      tap_val_d = '0;
      case (tap_q)
         2'd0:    tap_val_d = {2'b00, h_q[0]};
         2'd1:    tap_val_d = {2'b00, h_q[1]};
         2'd2:    tap_val_d = {2'b00, h_q[2]};
         2'd3:    tap_val_d = {2'b00, h_q[3]};
         default: tap_val_d = '0;
      endcase
   end

   rca_add #(.W(w + 2)) u_add (
      .a_i   (acc_q),
      .b_i   (tap_val_d),
      .sum_o (sum_d)
   );

   // Controller, history shift register, accumulator and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         for (int i = 0; i < NTAPS; i++) h_q[i] <= '0;
         tap_q       <= '0;
         acc_q       <= '0;
         s_q         <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  h_q[0]     <= a;
                  h_q[1]     <= h_q[0];
                  h_q[2]     <= h_q[1];
                  h_q[3]     <= h_q[2];
                  tap_q      <= '0;
                  acc_q      <= '0;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b0;
                  state_q    <= ACC;
               end else begin
                  state_q <= IDLE;
               end
            end
            ACC: begin
               acc_q <= sum_d;
               tap_q <= tap_q + 2'd1;
               if (tap_q == TAP_LAST) begin
                  s_q         <= sum_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  state_q <= ACC;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  state_q <= DONE;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir4_seq_ctrl.sv
// Scoreboard bench for fir4_seq_ctrl (w=16): directed vectors push expected sums,
// a monitor pops and compares at every output handshake.
module tb_fir4_seq_ctrl;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic        out_valid;
   logic        out_ready;
   logic [17:0] s;
   logic        busy;

   int errors = 0;
   int checks = 0;
   logic [17:0] exp_q [$];

   fir4_seq_ctrl #(.w(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every completed output handshake must match the oldest expected sum.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got s=0x%0h expected no output", s);
            end else begin
               check("scoreboard_s", {14'd0, s}, {14'd0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; a = 16'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Issue one sample, check the 4-edge latency; optionally keep in_valid high with a=7.
   task automatic send(input logic [15:0] val, input logic [17:0] expv, input bit hold);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      exp_q.push_back(expv);
      in_valid = 1'b1; a = val;
      @(posedge clk); #1;
      if (hold) begin
         in_valid = 1'b1; a = 16'd7;
      end else begin
         in_valid = 1'b0; a = 16'd0;
      end
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("lat_early", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk); #1;
      check("lat_valid", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("drain", exp_q.size(), 32'd0);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; a = 16'd0; out_ready = 1'b1;
      do_reset();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_s", {14'd0, s}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Ramp with zero-filled history.
      send(16'd1, 18'd1, 1'b0);
      send(16'd2, 18'd3, 1'b0);
      send(16'd3, 18'd6, 1'b0);
      send(16'd4, 18'd10, 1'b0);
      drain();

      // Full-scale samples: no wrap at the top.
      do_reset();
      send(16'hFFFF, 18'h0FFFF, 1'b0);
      send(16'hFFFF, 18'h1FFFE, 1'b0);
      send(16'hFFFF, 18'h2FFFD, 1'b0);
      send(16'hFFFF, 18'h3FFFC, 1'b0);
      drain();

      // Backpressure in DONE.
      do_reset();
      out_ready = 1'b0;
      send(16'd8, 18'd8, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("stall_s", {14'd0, s}, 32'd8);
         check("stall_valid", {31'd0, out_valid}, 32'd1);
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_valid", {31'd0, out_valid}, 32'd0);
      check("release_in_ready", {31'd0, in_ready}, 32'd1);
      check("release_busy", {31'd0, busy}, 32'd0);
      drain();

      // in_valid held with a=7 while busy must not touch history.
      do_reset();
      out_ready = 1'b0;
      send(16'd2, 18'd2, 1'b1);
      in_valid = 1'b0; a = 16'd0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      send(16'd3, 18'd5, 1'b0);
      drain();

      // Reset in the second ACC cycle aborts the operation.
      do_reset();
      in_valid = 1'b1; a = 16'd9;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 16'd0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_valid", {31'd0, out_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_s", {14'd0, s}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (6) @(posedge clk);
      #1;
      check("abort_no_pulse", {31'd0, out_valid}, 32'd0);
      send(16'd5, 18'd5, 1'b0);
      drain();

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
